// File: rtl/ext_timer_io_pkg.sv
// ext_timer_io_pkg: register offsets and bit positions shared by the timer/GPIO peripheral
// and anything that talks to it.
package ext_timer_io_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESC    = 3'd1;
  localparam logic [2:0] OFF_RELOAD   = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_GPIO_OUT = 3'd5;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int STAT_EXP  = 0;

endpackage

// File: rtl/ext_timer_io_prescaler.sv
// ext_prescaler: counts 0..presc while enabled and pulses tick for one cycle on the
// terminal count; clr restarts the count from 0.
module ext_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] presc,
  output logic        tick
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  assign tick = en && (pc_q == presc);

  // next prescaler count
  always_comb begin
    if (clr || !en) begin
      pc_d = 16'h0000;
    end else if (pc_q == presc) begin
      pc_d = 16'h0000;
    end else begin
      pc_d = pc_q + 16'h0001;
    end
  end

  // prescaler count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/ext_timer_io.sv
// ext_timer_io: memory-mapped prescaled down-counter with irq and an optional GPIO port.
// Define EXT_TIMER_IO_GPIO_EN to include GPIO_OUT, GPIO_IN and the input synchronizer.
module ext_timer_io
  import ext_timer_io_pkg::*;
#(
  parameter logic [15:0] BASE   = 16'hFF00,
  parameter int          GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  inout  wire  [15:0]       data_bus,
  input  logic              we,
  input  logic              re,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  logic        hit_s;
  logic        wr_s;
  logic        rd_s;
  logic [2:0]  off_s;
  logic        pc_clr_s;
  logic        tick_s;
  logic        tick_eff_s;
  logic        exp_set_s;
  logic [15:0] rdata_s;
  logic [15:0] gpio_out_ext_s;
  logic [15:0] gpio_in_ext_s;

  logic [2:0]  ctrl_q,   ctrl_d;
  logic [15:0] presc_q,  presc_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q,  count_d;
  logic        exp_q,    exp_d;

  assign hit_s = (addr[15:3] == BASE[15:3]);
  assign off_s = addr[2:0];
  assign wr_s  = we && hit_s;
  assign rd_s  = re && hit_s && !we;

  // The prescaler restarts on a PRESC write and when the timer is switched on.
  assign pc_clr_s = wr_s && ((off_s == OFF_PRESC) ||
                    ((off_s == OFF_CTRL) && data_bus[CTRL_EN] && !ctrl_q[CTRL_EN]));

  ext_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (pc_clr_s),
    .presc (presc_q),
    .tick  (tick_s)
  );

  // A CPU write to COUNT swallows a coincident tick entirely, expiry included.
  assign tick_eff_s = tick_s && !(wr_s && (off_s == OFF_COUNT));
  assign exp_set_s  = tick_eff_s && (count_q == 16'h0000);

  // timer next state: tick handling first, CPU writes override, expiry set wins over clear
  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;
    exp_d    = exp_q;
    if (tick_eff_s) begin
      if (count_q == 16'h0000) begin
        if (ctrl_q[CTRL_AUTO]) begin
          count_d = reload_q;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = count_q - 16'h0001;
      end
    end else begin
      count_d = count_q;
    end
    if (wr_s) begin
      case (off_s)
        OFF_CTRL:   ctrl_d   = data_bus[2:0];
        OFF_PRESC:  presc_d  = data_bus;
        OFF_RELOAD: reload_d = data_bus;
        OFF_COUNT:  count_d  = data_bus;
        OFF_STATUS: begin
          if (data_bus[STAT_EXP]) begin
            exp_d = 1'b0;
          end else begin
            exp_d = exp_q;
          end
        end
        default:    ctrl_d   = ctrl_d;
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end
    if (exp_set_s) begin
      exp_d = 1'b1;
    end else begin
      exp_d = exp_d;
    end
  end

  // timer register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= 3'b000;
      presc_q  <= 16'h0000;
      reload_q <= 16'h0000;
      count_q  <= 16'h0000;
      exp_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
    end
  end

  assign irq = exp_q && ctrl_q[CTRL_IE];

`ifdef EXT_TIMER_IO_GPIO_EN
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q,    sync1_d;
  logic [GPIO_W-1:0] sync2_q,    sync2_d;

  // GPIO next state and zero-extended read views
  always_comb begin
    gpio_out_d = (wr_s && (off_s == OFF_GPIO_OUT)) ? data_bus[GPIO_W-1:0] : gpio_out_q;
    sync1_d    = gpio_in;
    sync2_d    = sync1_q;
    gpio_out_ext_s = 16'h0000;
    gpio_in_ext_s  = 16'h0000;
    gpio_out_ext_s[GPIO_W-1:0] = gpio_out_q;
    gpio_in_ext_s[GPIO_W-1:0]  = sync2_q;
  end

  // GPIO output register and two-flop pin synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out_q <= {GPIO_W{1'b0}};
      sync1_q    <= {GPIO_W{1'b0}};
      sync2_q    <= {GPIO_W{1'b0}};
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  assign gpio_out = gpio_out_q;
`else
  logic unused_gpio_in_s;

  assign unused_gpio_in_s = ^gpio_in;
  assign gpio_out       = {GPIO_W{1'b0}};
  assign gpio_out_ext_s = 16'h0000;
  assign gpio_in_ext_s  = 16'h0000;
`endif

  // read mux
  always_comb begin
    rdata_s = 16'h0000;
    case (off_s)
      OFF_CTRL:     rdata_s = {13'd0, ctrl_q};
      OFF_PRESC:    rdata_s = presc_q;
      OFF_RELOAD:   rdata_s = reload_q;
      OFF_COUNT:    rdata_s = count_q;
      OFF_STATUS:   rdata_s = {15'd0, exp_q};
      OFF_GPIO_OUT: rdata_s = gpio_out_ext_s;
      OFF_GPIO_IN:  rdata_s = gpio_in_ext_s;
      default:      rdata_s = 16'h0000;
    endcase
  end

  assign data_bus = rd_s ? rdata_s : 16'hzzzz;

endmodule

// File: tb/tb_ext_timer_io.sv
// tb_ext_timer_io: table-driven register checks, directed timer/decode/GPIO sequences and
// randomized timer runs compared against an arithmetic model of the count/expiry schedule.
module tb_ext_timer_io;
  import ext_timer_io_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int          GW   = 8;
`ifdef EXT_TIMER_IO_GPIO_EN
  localparam bit GPIO_ON = 1'b1;
`else
  localparam bit GPIO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   addr;
  logic          we;
  logic          re;
  logic          drv_oe;
  logic [15:0]   drv_val;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out;
  logic          irq;
  wire  [15:0]   data_bus;

  int checks   = 0;
  int failures = 0;

  assign data_bus = drv_oe ? drv_val : 16'hzzzz;

  ext_timer_io #(.BASE(BASE), .GPIO_W(GW)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_bus (data_bus),
    .we       (we),
    .re       (re),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  off;
    logic [15:0] wdata;
    logic [15:0] rexp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Undriven bus: accepted as all-z (4-state) or all-0 (2-state resolution).
  task automatic check_released(input string name);
    checks++;
    if (!((data_bus === 16'hzzzz) || (data_bus === 16'h0000))) begin
      failures++;
      $display("FAIL %s actual=%h required=zzzz", name, data_bus);
    end
  endtask

  task automatic wr_addr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; drv_val = d; drv_oe = 1'b1; we = 1'b1; re = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0; drv_oe = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    wr_addr(BASE | {13'd0, off}, d);
  endtask

  task automatic rd_addr(input logic [15:0] a, output logic [15:0] v);
    addr = a; re = 1'b1; we = 1'b0;
    #1;
    v = data_bus;
    re = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [15:0] v);
    rd_addr(BASE | {13'd0, off}, v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count after t clocks from the enabling write: n ticks elapsed, first expiry at tick c0+1.
  function automatic logic [15:0] model_count(int t, int p, int c0, int r, bit au);
    int n;
    n = t / (p + 1);
    if (n <= c0) return 16'(c0 - n);
    if (!au) return 16'h0000;
    return 16'(r - ((n - c0 - 1) % (r + 1)));
  endfunction

  initial begin
    logic [15:0] v;
    int p, c0, r, tmax;
    bit au, ie, expd;

    reset = 1'b1; addr = BASE; we = 1'b0; re = 1'b0;
    drv_oe = 1'b0; drv_val = 16'h0000; gpio_in = '0;

    vecs[0] = '{OFF_CTRL,     16'hFFFA, 16'h0002};
    vecs[1] = '{OFF_PRESC,    16'h1234, 16'h1234};
    vecs[2] = '{OFF_RELOAD,   16'hBEEF, 16'hBEEF};
    vecs[3] = '{OFF_COUNT,    16'h0102, 16'h0102};
    vecs[4] = '{OFF_STATUS,   16'hFFFE, 16'h0000};
    vecs[5] = '{3'd7,         16'hFFFF, 16'h0000};
    vecs[6] = '{OFF_GPIO_OUT, 16'h00A5, GPIO_ON ? 16'h00A5 : 16'h0000};
    vecs[7] = '{OFF_GPIO_IN,  16'h1111, 16'h0000};

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_released("reset_bus_z");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      check($sformatf("reset_read_off%0d", i), v, 16'h0000);
    end
    check("reset_gpio_out", 16'(gpio_out), 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);

    // register table
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].off, vecs[i].wdata);
      rd(vecs[i].off, v);
      check($sformatf("table_off%0d", vecs[i].off), v, vecs[i].rexp);
    end

    // one-shot: expiry exactly 6 clocks after the enabling write
    wr(OFF_CTRL, 16'h0000);
    wr(OFF_PRESC, 16'h0001);
    wr(OFF_COUNT, 16'h0002);
    wr(OFF_CTRL, 16'h0005);
    repeat (5) step();
    check("oneshot_irq_t5", {15'd0, irq}, 16'h0000);
    step();
    check("oneshot_irq_t6", {15'd0, irq}, 16'h0001);
    rd(OFF_STATUS, v); check("oneshot_exp", v, 16'h0001);
    rd(OFF_CTRL, v);   check("oneshot_ctrl", v, 16'h0004);
    repeat (3) step();
    rd(OFF_COUNT, v);  check("oneshot_count_hold", v, 16'h0000);

    // auto-reload every 4 clocks, clear, then clear coinciding with set
    wr(OFF_CTRL, 16'h0000);
    wr(OFF_STATUS, 16'h0001);
    wr(OFF_PRESC, 16'h0000);
    wr(OFF_RELOAD, 16'h0003);
    wr(OFF_COUNT, 16'h0003);
    wr(OFF_CTRL, 16'h0003);
    repeat (3) step();
    rd(OFF_STATUS, v); check("auto_exp_t3", v, 16'h0000);
    step();
    rd(OFF_STATUS, v); check("auto_exp_t4", v, 16'h0001);
    rd(OFF_COUNT, v);  check("auto_reload_t4", v, 16'h0003);
    step();
    wr(OFF_STATUS, 16'h0001);
    rd(OFF_STATUS, v); check("auto_clear_t6", v, 16'h0000);
    step();
    wr(OFF_STATUS, 16'h0001);
    rd(OFF_STATUS, v); check("auto_set_beats_clear", v, 16'h0001);
    check("auto_irq_ie0", {15'd0, irq}, 16'h0000);

    // write to COUNT on a tick cycle wins
    wr(OFF_COUNT, 16'h0010);
    rd(OFF_COUNT, v); check("write_beats_tick", v, 16'h0010);
    step();
    rd(OFF_COUNT, v); check("count_after_write", v, 16'h000F);

    // decode
    wr(OFF_CTRL, 16'h0004);
    wr(OFF_STATUS, 16'h0001);
    addr = BASE; re = 1'b0; #1;
    check_released("bus_z_re0");
    addr = 16'hFEFF; re = 1'b1; #1; check_released("bus_z_FEFF");
    addr = 16'hFEF8; #1; check_released("bus_z_FEF8");
    addr = 16'hFF08; #1; check_released("bus_z_FF08");
    re = 1'b0;
    rd_addr(16'hFF07, v); check("read_FF07", v, 16'h0000);
    wr_addr(16'hFF01, 16'h00AA);
    rd_addr(16'hFF01, v); check("readback_FF01", v, 16'h00AA);
    wr_addr(16'hFF08, 16'h0003);
    rd(OFF_CTRL, v); check("miss_write_ignored", v, 16'h0004);

    // GPIO
    wr(OFF_GPIO_OUT, 16'h005A);
    check("gpio_out_pins", 16'(gpio_out), GPIO_ON ? 16'h005A : 16'h0000);
    rd(OFF_GPIO_OUT, v); check("gpio_out_read", v, GPIO_ON ? 16'h005A : 16'h0000);
    gpio_in = 8'hC3;
    step();
    rd(OFF_GPIO_IN, v); check("gpio_in_t1", v, 16'h0000);
    repeat (2) step();
    rd(OFF_GPIO_IN, v); check("gpio_in_t3", v, GPIO_ON ? 16'h00C3 : 16'h0000);

    // randomized runs against the arithmetic schedule
    for (int k = 0; k < 20; k++) begin
      p  = int'($urandom_range(3, 0));
      c0 = int'($urandom_range(5, 0));
      r  = int'($urandom_range(4, 0));
      au = 1'($urandom_range(1, 0));
      ie = 1'($urandom_range(1, 0));
      tmax = (c0 + 1) * (p + 1) + 2 * (r + 1) * (p + 1) + 2;
      wr(OFF_CTRL, 16'h0000);
      wr(OFF_STATUS, 16'h0001);
      wr(OFF_PRESC, 16'(p));
      wr(OFF_RELOAD, 16'(r));
      wr(OFF_COUNT, 16'(c0));
      wr(OFF_CTRL, {13'd0, ie, au, 1'b1});
      for (int t = 1; t <= tmax; t++) begin
        step();
        expd = (t / (p + 1)) >= (c0 + 1);
        rd(OFF_COUNT, v);
        check($sformatf("rand%0d_count_t%0d", k, t), v, model_count(t, p, c0, r, au));
        rd(OFF_STATUS, v);
        check($sformatf("rand%0d_exp_t%0d", k, t), v, {15'd0, expd});
        rd(OFF_CTRL, v);
        check($sformatf("rand%0d_ctrl_t%0d", k, t), v, {13'd0, ie, au, au | !expd});
        check($sformatf("rand%0d_irq_t%0d", k, t), {15'd0, irq}, {15'd0, expd & ie});
      end
    end

    // asynchronous reset mid-count
    wr(OFF_CTRL, 16'h0000);
    wr(OFF_PRESC, 16'h0000);
    wr(OFF_COUNT, 16'h0050);
    wr(OFF_CTRL, 16'h0005);
    repeat (3) step();
    reset = 1'b1;
    #1;
    rd(OFF_COUNT, v); check("async_reset_count", v, 16'h0000);
    rd(OFF_CTRL, v);  check("async_reset_ctrl", v, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) step();
    rd(OFF_STATUS, v); check("after_reset_exp", v, 16'h0000);
    check("after_reset_gpio_out", 16'(gpio_out), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
